// File: rtl/m2_pkg.sv
// Shared types and constants for the Milestone 2 SRAM block mover.
package m2_pkg;

    typedef enum logic [2:0] {
        S_M2_IDLE,
        S_M2_FETCH,
        S_M2_FETCH_DRAIN,
        S_M2_WRITE,
        S_M2_WRITE_DRAIN,
        S_M2_DONE
    } m2_state_type;

    // Pre-IDCT coefficient regions, one signed word per sample
    localparam logic [17:0] SP_Y_BASE  = 18'd76800;
    localparam logic [17:0] SP_U_BASE  = 18'd153600;
    localparam logic [17:0] SP_V_BASE  = 18'd192000;

    // Finished sample regions, two 8-bit samples per word
    localparam logic [17:0] OUT_Y_BASE = 18'd0;
    localparam logic [17:0] OUT_U_BASE = 18'd38400;
    localparam logic [17:0] OUT_V_BASE = 18'd57600;

    localparam int Y_BLOCKS     = 1200;
    localparam int UV_BLOCKS    = 600;
    localparam int TOTAL_BLOCKS = 2400;

endpackage

// File: rtl/m2_block_addr_gen.sv
// Maps (block index, row, column, direction) to an 18-bit SRAM word address.
// Row strides of 320/160/80 are built from shifts and adds.
module m2_block_addr_gen
    import m2_pkg::*;
#(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
)
(
    input  logic [11:0] blk_idx,
    input  logic [2:0]  row,
    input  logic [2:0]  col,
    input  logic        wr,
    output logic [17:0] addr
);

    localparam int          Y_BCOLS = IMG_W / 8;
    localparam int          C_BCOLS = IMG_W / 16;
    localparam int          BROWS   = IMG_H / 8;
    localparam logic [11:0] U_START = 12'(BROWS * Y_BCOLS);
    localparam logic [11:0] V_START = 12'(BROWS * (Y_BCOLS + C_BCOLS));

    logic        is_y;
    logic        is_u;
    logic [11:0] rel;
    logic [4:0]  by;
    logic [5:0]  bx;
    logic [17:0] line;

    // Segment decode, block position within the segment, then address sum
    always_comb begin
        is_y = (blk_idx < U_START);
        is_u = !is_y && (blk_idx < V_START);
        rel  = blk_idx;
        if (is_u) begin
            rel = blk_idx - U_START;
        end else if (!is_y) begin
            rel = blk_idx - V_START;
        end
        if (is_y) begin
            by = 5'(rel / 12'(Y_BCOLS));
            bx = 6'(rel % 12'(Y_BCOLS));
        end else begin
            by = 5'(rel / 12'(C_BCOLS));
            bx = 6'(rel % 12'(C_BCOLS));
        end
        // Image row is by*8+r, which is just a concatenation
        line = {10'd0, by, row};
        if (!wr) begin
            if (is_y) begin
                addr = SP_Y_BASE + (line << 8) + (line << 6)
                     + {9'd0, bx, 3'd0} + {15'd0, col};
            end else begin
                addr = (is_u ? SP_U_BASE : SP_V_BASE) + (line << 7) + (line << 5)
                     + {9'd0, bx, 3'd0} + {15'd0, col};
            end
        end else begin
            if (is_y) begin
                addr = OUT_Y_BASE + (line << 7) + (line << 5)
                     + {10'd0, bx, 2'd0} + {16'd0, col[2:1]};
            end else begin
                addr = (is_u ? OUT_U_BASE : OUT_V_BASE) + (line << 6) + (line << 4)
                     + {10'd0, bx, 2'd0} + {16'd0, col[2:1]};
            end
        end
    end

endmodule

// File: rtl/m2_block_mover.sv
// Milestone 2 SRAM mover: fetches 8x8 S' blocks into the IDCT buffer and
// writes packed 8-bit S blocks back to the Y/U/V output regions.
module m2_block_mover
    import m2_pkg::*;
#(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
)
(
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        cmd_valid,
    input  logic        cmd_write,
    output logic        cmd_ready,
    output logic        done,
    output logic        last_block,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    output logic [5:0]  sp_addr,
    output logic [15:0] sp_wdata,
    output logic        sp_we,
    output logic [4:0]  s_addr,
    input  logic [15:0] s_rdata
);

    localparam logic [11:0] LAST_IDX = 12'(TOTAL_BLOCKS - 1);

    m2_state_type state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [4:0]   s_addr_q, s_addr_d;
    logic [11:0]  fetch_idx_q, fetch_idx_d;
    logic [11:0]  write_idx_q, write_idx_d;
    logic         wr_mode_q, wr_mode_d;
    logic [17:0]  sram_addr_q, sram_addr_d;
    logic         we_n_q, we_n_d;
    logic         rd_vld_p1_q, rd_vld_p1_d;
    logic [5:0]   rd_idx_p1_q, rd_idx_p1_d;
    logic         sp_we_q, sp_we_d;
    logic [5:0]   sp_addr_q, sp_addr_d;

    logic [11:0]  gen_blk;
    logic [5:0]   gen_k;
    logic         gen_wr;
    logic [2:0]   gen_r;
    logic [2:0]   gen_c;
    logic [17:0]  gen_addr;

    // Address generator operands: fetch looks one sample ahead, write-back
    // registers the address of the word whose S data returns next cycle
    always_comb begin
        gen_wr  = 1'b0;
        gen_blk = fetch_idx_q;
        gen_k   = 6'd0;
        case (state_q)
            S_M2_FETCH: gen_k = cnt_q + 6'd1;
            S_M2_WRITE: begin
                gen_wr  = 1'b1;
                gen_blk = write_idx_q;
                gen_k   = cnt_q;
            end
            default: ;
        endcase
        if (gen_wr) begin
            gen_r = gen_k[4:2];
            gen_c = {gen_k[1:0], 1'b0};
        end else begin
            gen_r = gen_k[5:3];
            gen_c = gen_k[2:0];
        end
    end

    m2_block_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_addr_gen (
        .blk_idx (gen_blk),
        .row     (gen_r),
        .col     (gen_c),
        .wr      (gen_wr),
        .addr    (gen_addr)
    );

    // Next-state, counters and the read/write pipelines
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        s_addr_d    = s_addr_q;
        fetch_idx_d = fetch_idx_q;
        write_idx_d = write_idx_q;
        wr_mode_d   = wr_mode_q;
        sram_addr_d = sram_addr_q;
        // SRAM data returns two cycles after the address is driven
        rd_vld_p1_d = (state_q == S_M2_FETCH);
        rd_idx_p1_d = cnt_q;
        sp_we_d     = rd_vld_p1_q;
        sp_addr_d   = rd_vld_p1_q ? rd_idx_p1_q : sp_addr_q;
        // S buffer data returns one cycle after s_addr, aligned with the write
        we_n_d      = (state_q != S_M2_WRITE);

        case (state_q)
            S_M2_IDLE: begin
                if (cmd_valid) begin
                    wr_mode_d = cmd_write;
                    cnt_d     = 6'd0;
                    s_addr_d  = 5'd0;
                    if (cmd_write) begin
                        state_d = S_M2_WRITE;
                    end else begin
                        state_d     = S_M2_FETCH;
                        sram_addr_d = gen_addr;
                    end
                end
            end
            S_M2_FETCH: begin
                if (cnt_q == 6'd63) begin
                    state_d = S_M2_FETCH_DRAIN;
                end else begin
                    cnt_d       = cnt_q + 6'd1;
                    sram_addr_d = gen_addr;
                end
            end
            S_M2_FETCH_DRAIN: begin
                if (sp_we_q && (sp_addr_q == 6'd63)) begin
                    state_d = S_M2_DONE;
                end
            end
            S_M2_WRITE: begin
                sram_addr_d = gen_addr;
                if (cnt_q == 6'd31) begin
                    state_d = S_M2_WRITE_DRAIN;
                end else begin
                    cnt_d    = cnt_q + 6'd1;
                    s_addr_d = 5'(cnt_q + 6'd1);
                end
            end
            S_M2_WRITE_DRAIN: begin
                if (!we_n_q) begin
                    state_d = S_M2_DONE;
                end
            end
            S_M2_DONE: begin
                state_d = S_M2_IDLE;
                if (wr_mode_q) begin
                    write_idx_d = (write_idx_q == LAST_IDX) ? 12'd0 : write_idx_q + 12'd1;
                end else begin
                    fetch_idx_d = (fetch_idx_q == LAST_IDX) ? 12'd0 : fetch_idx_q + 12'd1;
                end
            end
            default: state_d = S_M2_IDLE;
        endcase
    end

    // State and pipeline registers; reset aborts any command in flight
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= S_M2_IDLE;
            cnt_q       <= 6'd0;
            s_addr_q    <= 5'd0;
            fetch_idx_q <= 12'd0;
            write_idx_q <= 12'd0;
            wr_mode_q   <= 1'b0;
            sram_addr_q <= 18'd0;
            we_n_q      <= 1'b1;
            rd_vld_p1_q <= 1'b0;
            rd_idx_p1_q <= 6'd0;
            sp_we_q     <= 1'b0;
            sp_addr_q   <= 6'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_addr_q    <= s_addr_d;
            fetch_idx_q <= fetch_idx_d;
            write_idx_q <= write_idx_d;
            wr_mode_q   <= wr_mode_d;
            sram_addr_q <= sram_addr_d;
            we_n_q      <= we_n_d;
            rd_vld_p1_q <= rd_vld_p1_d;
            rd_idx_p1_q <= rd_idx_p1_d;
            sp_we_q     <= sp_we_d;
            sp_addr_q   <= sp_addr_d;
        end
    end

    assign cmd_ready       = (state_q == S_M2_IDLE);
    assign done            = (state_q == S_M2_DONE);
    assign last_block      = done && ((wr_mode_q ? write_idx_q : fetch_idx_q) == LAST_IDX);
    assign SRAM_address    = sram_addr_q;
    assign SRAM_we_n       = we_n_q;
    assign SRAM_write_data = we_n_q ? 16'd0 : s_rdata;
    assign sp_we           = sp_we_q;
    assign sp_addr         = sp_addr_q;
    assign sp_wdata        = sp_we_q ? SRAM_read_data : 16'd0;
    assign s_addr          = s_addr_q;

endmodule

// File: tb/tb_m2_block_mover.sv
// Directed bench for m2_block_mover with a 2-cycle SRAM model and a
// 1-cycle S buffer model.
module tb_m2_block_mover;

    logic        Clock;
    logic        Resetn;
    logic        cmd_valid;
    logic        cmd_write;
    logic        cmd_ready;
    logic        done;
    logic        last_block;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;
    logic [5:0]  sp_addr;
    logic [15:0] sp_wdata;
    logic        sp_we;
    logic [4:0]  s_addr;
    logic [15:0] s_rdata;

    logic [11:0] ag_blk;
    logic [2:0]  ag_r;
    logic [2:0]  ag_c;
    logic        ag_wr;
    logic [17:0] ag_addr;

    m2_block_mover dut (
        .Clock           (Clock),
        .Resetn          (Resetn),
        .cmd_valid       (cmd_valid),
        .cmd_write       (cmd_write),
        .cmd_ready       (cmd_ready),
        .done            (done),
        .last_block      (last_block),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .SRAM_read_data  (SRAM_read_data),
        .sp_addr         (sp_addr),
        .sp_wdata        (sp_wdata),
        .sp_we           (sp_we),
        .s_addr          (s_addr),
        .s_rdata         (s_rdata)
    );

    m2_block_addr_gen u_ag (
        .blk_idx (ag_blk),
        .row     (ag_r),
        .col     (ag_c),
        .wr      (ag_wr),
        .addr    (ag_addr)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // SRAM read model: two-cycle latency
    logic [15:0] mem [0:262143];
    logic [15:0] rd_p1;
    logic [15:0] rd_p2;
    always @(posedge Clock) begin
        rd_p1 <= mem[SRAM_address];
        rd_p2 <= rd_p1;
    end
    assign SRAM_read_data = rd_p2;

    // S buffer model: one-cycle latency, counting pattern or constant
    logic s_mode;
    always @(posedge Clock) begin
        s_rdata <= s_mode ? 16'hA55A : (16'h1000 | {11'd0, s_addr});
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic int sp_model(int blk, int k);
        int base, w, bc, rel;
        if (blk < 1200) begin
            base = 76800;  w = 320; bc = 40; rel = blk;
        end else if (blk < 1800) begin
            base = 153600; w = 160; bc = 20; rel = blk - 1200;
        end else begin
            base = 192000; w = 160; bc = 20; rel = blk - 1800;
        end
        return base + ((rel / bc) * 8 + k / 8) * w + (rel % bc) * 8 + k % 8;
    endfunction

    function automatic int out_model(int blk, int j);
        int base, wpr, bc, rel;
        if (blk < 1200) begin
            base = 0;     wpr = 160; bc = 40; rel = blk;
        end else if (blk < 1800) begin
            base = 38400; wpr = 80;  bc = 20; rel = blk - 1200;
        end else begin
            base = 57600; wpr = 80;  bc = 20; rel = blk - 1800;
        end
        return base + ((rel / bc) * 8 + j / 4) * wpr + (rel % bc) * 4 + j % 4;
    endfunction

    function automatic logic [15:0] mem_init(int a);
        return 16'(a) ^ 16'h5A5A;
    endfunction

    logic [17:0] a_log    [0:127];
    logic        we_log   [0:127];
    logic [15:0] wd_log   [0:127];
    logic        spwe_log [0:127];
    logic [5:0]  spa_log  [0:127];
    logic [15:0] spd_log  [0:127];
    logic [4:0]  sa_log   [0:127];
    int          done_cyc;
    int          busy_ready;
    int          acc_wait;
    logic        lb;
    logic        got_done;
    logic        after_ready;
    logic        after_done;

    // Issue one command, log every cycle until done, end on cycle done+1
    task automatic do_cmd(input logic w, input logic hold);
        int guard;
        guard      = 0;
        done_cyc   = 999;
        busy_ready = 0;
        got_done   = 1'b0;
        lb         = 1'b0;
        cmd_write  = w;
        cmd_valid  = 1'b1;
        while (!cmd_ready && guard < 200) begin
            step();
            guard++;
        end
        acc_wait = guard;
        chk("ready_wait", cmd_ready, 1);
        step();
        if (!hold) cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 120; cyc++) begin
            a_log[cyc]    = SRAM_address;
            we_log[cyc]   = SRAM_we_n;
            wd_log[cyc]   = SRAM_write_data;
            spwe_log[cyc] = sp_we;
            spa_log[cyc]  = sp_addr;
            spd_log[cyc]  = sp_wdata;
            sa_log[cyc]   = s_addr;
            if (cmd_ready) busy_ready++;
            if (done) begin
                done_cyc = cyc;
                lb       = last_block;
                got_done = 1'b1;
                break;
            end
            step();
        end
        chk("done_seen", got_done, 1);
        step();
        after_ready = cmd_ready;
        after_done  = done;
    endtask

    int zeros;
    int nseen;

    initial begin
        for (int a = 0; a < 262144; a++) mem[a] = mem_init(a);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mem[76800 + r * 320 + c] = 16'(r * 8 + c);
        s_mode    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        ag_blk    = 12'd0;
        ag_r      = 3'd0;
        ag_c      = 3'd0;
        ag_wr     = 1'b0;
        Resetn    = 1'b0;
        repeat (3) step();

        // Reset values
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_last_block", last_block, 0);
        chk("rst_sram_addr", SRAM_address, 0);
        chk("rst_sram_wdata", SRAM_write_data, 0);
        chk("rst_we_n", SRAM_we_n, 1);
        chk("rst_sp_addr", sp_addr, 0);
        chk("rst_sp_wdata", sp_wdata, 0);
        chk("rst_sp_we", sp_we, 0);
        chk("rst_s_addr", s_addr, 0);
        Resetn = 1'b1;
        repeat (2) step();

        // Fetch block 0: preloaded data equals sample index
        do_cmd(1'b0, 1'b0);
        for (int k = 0; k < 64; k++) begin
            chk("f0_addr", a_log[1 + k], sp_model(0, k));
            chk("f0_sp_we", spwe_log[3 + k], 1);
            chk("f0_sp_addr", spa_log[3 + k], k);
            chk("f0_sp_wdata", spd_log[3 + k], k);
        end
        chk("f0_first_addr", a_log[1], 76800);
        chk("f0_sp_we_before", spwe_log[2], 0);
        chk("f0_sp_we_after", spwe_log[67], 0);
        zeros = 0;
        for (int c = 1; c <= 67; c++) if (!we_log[c]) zeros++;
        chk("f0_we_n_high", zeros, 0);
        chk("f0_done_cyc", done_cyc, 67);
        chk("f0_last_block", lb, 0);
        chk("f0_busy_ready", busy_ready, 0);
        chk("f0_ready_after", after_ready, 1);
        chk("f0_done_pulse", after_done, 0);

        // Fetch block 1 with cmd_valid held, then block 2 back to back
        do_cmd(1'b0, 1'b1);
        chk("hold_first_addr", a_log[1], sp_model(1, 0));
        chk("hold_last_addr", a_log[64], sp_model(1, 63));
        chk("hold_sp_wdata", spd_log[8], mem_init(sp_model(1, 5)));
        chk("hold_busy_ready", busy_ready, 0);
        chk("hold_done_cyc", done_cyc, 67);
        chk("hold_cmd_valid_still", cmd_valid, 1);
        do_cmd(1'b0, 1'b0);
        chk("hold_b2b_wait", acc_wait, 0);
        chk("hold_b2_first", a_log[1], sp_model(2, 0));
        chk("hold_b2_done", done_cyc, 67);

        // Reset at cycle 30 of a fetch of block 3
        cmd_write = 1'b0;
        cmd_valid = 1'b1;
        chk("mid_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        repeat (29) step();
        chk("mid_pre_addr", SRAM_address, sp_model(3, 29));
        #2 Resetn = 1'b0;
        #1;
        chk("mid_rst_addr", SRAM_address, 0);
        chk("mid_rst_sp_we", sp_we, 0);
        chk("mid_rst_sp_addr", sp_addr, 0);
        chk("mid_rst_sp_wdata", sp_wdata, 0);
        chk("mid_rst_we_n", SRAM_we_n, 1);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_done", done, 0);
        repeat (3) step();
        Resetn = 1'b1;
        nseen = 0;
        for (int c = 0; c < 80; c++) begin
            if (done) nseen++;
            step();
        end
        chk("mid_no_done", nseen, 0);
        do_cmd(1'b0, 1'b0);
        chk("mid_next_first", a_log[1], 76800);
        chk("mid_next_row1", a_log[9], 77120);
        chk("mid_next_data", spd_log[13], 10);
        chk("mid_next_done", done_cyc, 67);

        // Write-back block 0 with a counting S pattern
        do_cmd(1'b1, 1'b0);
        for (int j = 0; j < 32; j++) begin
            chk("w0_s_addr", sa_log[1 + j], j);
            chk("w0_we_n", we_log[2 + j], 0);
            chk("w0_addr", a_log[2 + j], out_model(0, j));
            chk("w0_wdata", wd_log[2 + j], 16'h1000 | j);
        end
        chk("w0_we_n_before", we_log[1], 1);
        chk("w0_we_n_after", we_log[34], 1);
        chk("w0_done_cyc", done_cyc, 34);

        // Remaining write-backs through block 2399, then the wrap
        s_mode = 1'b1;
        for (int blk = 1; blk < 2400; blk++) begin
            do_cmd(1'b1, 1'b0);
            chk("wb_first", a_log[2], out_model(blk, 0));
            chk("wb_last", a_log[33], out_model(blk, 31));
            chk("wb_done_cyc", done_cyc, 34);
            chk("wb_last_block", lb, (blk == 2399) ? 1 : 0);
            if (blk == 39) begin
                for (int j = 0; j < 32; j++) begin
                    chk("b39_addr", a_log[2 + j], 156 + (j / 4) * 160 + j % 4);
                    chk("b39_data", wd_log[2 + j], 16'hA55A);
                end
                chk("b39_end", a_log[33], 1279);
            end
            if (blk == 1800) chk("b1800_first", a_log[2], 57600);
            if (blk == 2399) chk("b2399_end", a_log[33], 76799);
        end
        do_cmd(1'b1, 1'b0);
        chk("wrap_first", a_log[2], 0);
        chk("wrap_last_block", lb, 0);

        // Fetch-side address mapping for the first U and V blocks
        ag_wr = 1'b0; ag_blk = 12'd1200; ag_r = 3'd0; ag_c = 3'd0; #1;
        chk("ag_u_first", ag_addr, 153600);
        ag_r = 3'd1; #1;
        chk("ag_u_row1", ag_addr, 153760);
        ag_r = 3'd7; ag_c = 3'd7; #1;
        chk("ag_u_last", ag_addr, 154727);
        ag_blk = 12'd1199; #1;
        chk("ag_y_end", ag_addr, 153599);
        ag_blk = 12'd1800; ag_r = 3'd0; ag_c = 3'd0; #1;
        chk("ag_v_first", ag_addr, 192000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
